mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory between the CPU controller (fetch, LDA/STA/ADA/ANA
//  operand access) and a debug/loader port. Arbitrates, issues one access at a time to the memory, and returns
//  read data to the owner. The CPU controller holds its state until gnt/rvalid.
// PARAMETERS
//  ADDR_W     12  memory address width
//  DATA_W     16  memory data width
//  MEM_LAT    1   read latency: cycles from mem_en to valid mem_rdata (1..4)
//  STARVE_MAX 4   consecutive CPU wins over a pending dbg_req before dbg is forced to win (1..15)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  cpu_req     in   1       CPU access request, held until cpu_gnt
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       1-cycle pulse: CPU access issued to memory
//  cpu_rvalid  out  1       1-cycle pulse: cpu_rdata valid
//  cpu_rdata   out  DATA_W  read data (0 when cpu_rvalid=0)
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_gnt/dbg_rvalid/dbg_rdata  same as cpu_*, debug port
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable (valid with mem_en)
//  mem_adr     out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data
//  busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0, owner=CPU; all outputs 0. Reset mid-access drops it: no gnt/rvalid follows.
//  - FSM IDLE -> ISSUE -> (read: WAIT -> IDLE | write: IDLE).
//    IDLE: if any req, pick winner, register its we/addr/wdata and owner; next state ISSUE.
//    ISSUE (1 cycle): mem_en=1, mem_we/adr/wdata from registers, owner's gnt=1.
//    WAIT (MEM_LAT cycles): down-counter; on its last cycle owner's rvalid=1, rdata=mem_rdata; -> IDLE.
//  - Latency: req seen in cycle N -> gnt/mem_en in N+1 -> rvalid in N+1+MEM_LAT. Next issue no earlier than the
//    cycle after rvalid (read) or N+3 (write). One outstanding access only.
//  - mem_* outputs registered; mem_adr/mem_wdata hold last value, mem_we=0 when mem_en=0.
//  - Requester keeps addr/we/wdata stable while req=1 and before gnt; req held after gnt = new request.
//  - Arbitration (default): CPU fixed priority. starve_cnt increments when CPU wins with dbg_req=1; if
//    starve_cnt==STARVE_MAX and dbg_req=1, dbg wins and starve_cnt clears. Cleared on any dbg grant.
//  - Simultaneous req: CPU wins unless starve_cnt==STARVE_MAX. Single req always wins.
//  - Requests arriving during ISSUE/WAIT are not lost; they are evaluated at next IDLE.
//  - Write to an address during WAIT of a read is impossible (single outstanding); no hazard logic.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; the requester not granted last wins a tie (last-owner reset = dbg, so
//    CPU wins first tie); starve_cnt removed, STARVE_MAX ignored.
//  MEM_ARB_RR_EN undefined: fixed CPU priority with starvation counter as above.
// TESTING
//  1. MEM_LAT=1, cpu read 0x010 (mem holds 0x1234): req@N -> cpu_gnt@N+1, cpu_rvalid@N+2 with rdata=0x1234.
//  2. dbg write 0x020<=0xBEEF then cpu read 0x020 -> mem_we=1 with adr 0x020 on dbg_gnt; cpu_rdata=0xBEEF.
//  3. cpu_req and dbg_req held high, STARVE_MAX=4 -> grant order C,C,C,C,D,C,C,C,C,D...; dbg never waits >5 grants.
//  4. MEM_LAT=3, read in WAIT, assert rst -> all outputs 0 next edge, no rvalid; first req after release
//     gnts 1 cycle later.
//  5. MEM_ARB_RR_EN, both held -> grants alternate C,D,C,D; busy=0 only in IDLE cycles between accesses.
//  6. cpu_req rises during dbg WAIT (MEM_LAT=2) -> dbg_rvalid first, then cpu_gnt 2 cycles later; no request lost.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between the CPU controller and a debug/loader port
// MEM_ARB_RR_EN: round-robin tie-break instead of CPU priority with a starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_adr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_wait_cnt;
    logic              r_owner_dbg;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_any_req;
    logic              w_pick_dbg;
    logic              w_rd_done;
`ifdef MEM_ARB_RR_EN
    logic              r_last_dbg;
`else
    logic [3:0]        r_starve_cnt;
`endif

    assign w_any_req = i_cpu_req | i_dbg_req;

    always_comb begin
        w_pick_dbg = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (i_cpu_req && i_dbg_req)
            w_pick_dbg = ~r_last_dbg;
        else
            w_pick_dbg = i_dbg_req;
`else
        // The debug port only beats a waiting CPU once it has been passed over STARVE_MAX times.
        if (i_dbg_req && (!i_cpu_req || r_starve_cnt == 4'(STARVE_MAX)))
            w_pick_dbg = 1'b1;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = r_mem_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (r_wait_cnt == 2'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 2'd0;
            r_owner_dbg <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_dbg  <= 1'b1;
`else
            r_starve_cnt <= 4'd0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_state == S_IDLE && w_any_req) begin
                r_mem_en    <= 1'b1;
                r_owner_dbg <= w_pick_dbg;
                r_mem_we    <= w_pick_dbg ? i_dbg_we    : i_cpu_we;
                r_mem_adr   <= w_pick_dbg ? i_dbg_addr  : i_cpu_addr;
                r_mem_wdata <= w_pick_dbg ? i_dbg_wdata : i_cpu_wdata;
`ifdef MEM_ARB_RR_EN
                r_last_dbg  <= w_pick_dbg;
`else
                if (w_pick_dbg)
                    r_starve_cnt <= 4'd0;
                else if (i_dbg_req)
                    r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
            end
            if (r_state == S_ISSUE)
                r_wait_cnt <= 2'(MEM_LAT - 1);
            else if (r_state == S_WAIT && r_wait_cnt != 2'd0)
                r_wait_cnt <= r_wait_cnt - 2'd1;
        end
    end

    // Read data is valid in the final WAIT cycle, so it is steered straight from the memory bus.
    assign w_rd_done    = (r_state == S_WAIT) && (r_wait_cnt == 2'd0);
    assign o_cpu_gnt    = (r_state == S_ISSUE) && !r_owner_dbg;
    assign o_dbg_gnt    = (r_state == S_ISSUE) &&  r_owner_dbg;
    assign o_cpu_rvalid = w_rd_done && !r_owner_dbg;
    assign o_dbg_rvalid = w_rd_done &&  r_owner_dbg;
    assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
    assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : '0;
    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_adr    = r_mem_adr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter against a transaction-level reference model
module tb_mem_port_arbiter;
    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_adr(mem_adr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 12'h010) ? 16'h1234 : {4'hA, a};
    endfunction

    // Memory with LAT-cycle read pipeline; idle stages carry a poison value.
    bit   [DW-1:0] ram     [0:(1<<AW)-1];
    bit            wr_seen [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:LAT-1];
    assign mem_rdata = rd_pipe[LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_adr]     <= mem_wdata;
            wr_seen[mem_adr] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (wr_seen[mem_adr] ? ram[mem_adr] : init_val(mem_adr)) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: transaction bookkeeping in absolute cycle numbers.
    logic [DW-1:0] mdl [0:(1<<AW)-1];
    int            cyc = 0;
    int            idle_from, g_cyc, rv_cyc;
    bit            g_dbg, g_we;
    logic [AW-1:0] g_adr;
    logic [DW-1:0] g_wd, rv_data;
`ifdef MEM_ARB_RR_EN
    bit            last_dbg;
`else
    int            starve;
`endif
    int            p_cpu = 0, p_dbg = 0;
    int            cpu_gnt_cyc = -1, cpu_rv_cyc = -1, dbg_rv_cyc = -1;
    logic [DW-1:0] last_cpu_rd = '0;
    logic          dbg_gnt_we = 1'b0;
    logic [AW-1:0] dbg_gnt_adr = '0;
    bit            gseq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        idle_from = 0; g_cyc = -1; rv_cyc = -1;
        g_dbg = 1'b0; g_we = 1'b0; g_adr = '0; g_wd = '0; rv_data = '0;
`ifdef MEM_ARB_RR_EN
        last_dbg = 1'b1;
`else
        starve = 0;
`endif
    endtask

    task automatic decide();
        bit pick_dbg;
        if (rst || cyc < idle_from || !(cpu_req || dbg_req)) return;
`ifdef MEM_ARB_RR_EN
        pick_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;
        last_dbg = pick_dbg;
`else
        pick_dbg = (cpu_req && dbg_req) ? (starve == SMAX) : dbg_req;
        if (pick_dbg) starve = 0;
        else if (dbg_req) starve++;
`endif
        g_cyc = cyc + 1;
        g_dbg = pick_dbg;
        g_we  = pick_dbg ? dbg_we    : cpu_we;
        g_adr = pick_dbg ? dbg_addr  : cpu_addr;
        g_wd  = pick_dbg ? dbg_wdata : cpu_wdata;
        if (g_we) begin
            mdl[g_adr] = g_wd;
            rv_cyc     = -1;
            idle_from  = cyc + 2;
        end else begin
            rv_cyc    = cyc + 1 + LAT;
            rv_data   = mdl[g_adr];
            idle_from = cyc + 2 + LAT;
        end
    endtask

    task automatic check_cycle();
        bit eg, ev;
        eg = (cyc == g_cyc);
        ev = (cyc == rv_cyc);
        chk("cpu_gnt",    32'(cpu_gnt),    32'(eg && !g_dbg));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(eg && g_dbg));
        chk("mem_en",     32'(mem_en),     32'(eg));
        chk("mem_we",     32'(mem_we),     32'(eg && g_we));
        chk("mem_adr",    32'(mem_adr),    32'(g_adr));
        chk("mem_wdata",  32'(mem_wdata),  32'(g_wd));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev && !g_dbg));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev && g_dbg));
        chk("cpu_rdata",  32'(cpu_rdata),  (ev && !g_dbg) ? 32'(rv_data) : 32'd0);
        chk("dbg_rdata",  32'(dbg_rdata),  (ev && g_dbg) ? 32'(rv_data) : 32'd0);
        chk("busy",       32'(busy),       32'(cyc < idle_from));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_cycle();
        if (cpu_gnt || dbg_gnt) gseq.push_back(dbg_gnt);
        if (cpu_gnt) cpu_gnt_cyc = cyc;
        if (dbg_gnt) begin
            dbg_gnt_we  = mem_we;
            dbg_gnt_adr = mem_adr;
        end
        if (cpu_rvalid) begin
            cpu_rv_cyc  = cyc;
            last_cpu_rd = cpu_rdata;
        end
        if (dbg_rvalid) dbg_rv_cyc = cyc;
    endtask

    task automatic post_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    endtask

    task automatic post_dbg(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            decide();
            tick();
            if (cpu_gnt) cpu_req = 1'b0;
            if (dbg_gnt) dbg_req = 1'b0;
            if (!rst && !cpu_req && $urandom_range(99) < p_cpu)
                post_cpu(1'($urandom_range(1)), 12'($urandom_range(31)), 16'($urandom));
            if (!rst && !dbg_req && $urandom_range(99) < p_dbg)
                post_dbg(1'($urandom_range(1)), 12'($urandom_range(31)), 16'($urandom));
        end
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; dbg_req = 1'b0; p_cpu = 0; p_dbg = 0;
        rst = 1'b1;
        model_reset();
        run(2);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int t0;
        for (int i = 0; i < (1 << AW); i++) mdl[i] = init_val(12'(i));
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 16'hDEAD;
        model_reset();
        run(3);
        rst = 1'b0;
        model_reset();
        run(2);

        // Single CPU read: gnt one cycle after the request, data LAT cycles later.
        post_cpu(1'b0, 12'h010, 16'h0);
        t0 = cyc;
        run(LAT + 4);
        chk("t1_gnt_cycle", 32'(cpu_gnt_cyc), 32'(t0 + 1));
        chk("t1_rv_cycle",  32'(cpu_rv_cyc),  32'(t0 + 1 + LAT));
        chk("t1_rdata",     32'(last_cpu_rd), 32'h1234);

        // Debug write followed by CPU read-back.
        post_dbg(1'b1, 12'h020, 16'hBEEF);
        run(4);
        chk("t2_dbg_we",  32'(dbg_gnt_we),  32'd1);
        chk("t2_dbg_adr", 32'(dbg_gnt_adr), 32'h020);
        post_cpu(1'b0, 12'h020, 16'h0);
        run(LAT + 4);
        chk("t2_readback", 32'(last_cpu_rd), 32'hBEEF);

        // CPU request arrives while a debug read is waiting for data.
        post_dbg(1'b0, 12'h005, 16'h0);
        t0 = cyc;
        run(2);
        post_cpu(1'b0, 12'h006, 16'h0);
        run(LAT + 6);
        chk("t6_dbg_rv",  32'(dbg_rv_cyc),  32'(t0 + 1 + LAT));
        chk("t6_cpu_gnt", 32'(cpu_gnt_cyc), 32'(t0 + 3 + LAT));

        // Both ports permanently requesting: grant pattern.
        do_reset();
        gseq.delete();
        p_cpu = 100; p_dbg = 100;
        run(60);
        p_cpu = 0; p_dbg = 0;
        chk("t3_count", 32'(gseq.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < gseq.size(); k++) begin
`ifdef MEM_ARB_RR_EN
            chk("t3_order", 32'(gseq[k]), 32'((k % 2) == 1));
`else
            chk("t3_order", 32'(gseq[k]), 32'((k % 5) == 4));
`endif
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        run(LAT + 4);

        // Reset while a read sits in WAIT: access is dropped.
        post_cpu(1'b0, 12'h007, 16'h0);
        run(2);
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_cycle();
        chk("t4_busy_in_rst", 32'(busy), 32'd0);
        run(3);
        rst = 1'b0;
        model_reset();
        cpu_rv_cyc = -1;
        run(LAT + 3);
        chk("t4_no_rvalid", 32'(cpu_rv_cyc), 32'hFFFF_FFFF);
        post_cpu(1'b0, 12'h008, 16'h0);
        t0 = cyc;
        run(LAT + 3);
        chk("t4_gnt_after_rst", 32'(cpu_gnt_cyc), 32'(t0 + 1));

        // Randomized traffic, then saturated traffic, then drain.
        p_cpu = 45; p_dbg = 35;
        run(800);
        p_cpu = 100; p_dbg = 100;
        run(200);
        p_cpu = 0; p_dbg = 0;
        run(2);
        cpu_req = 1'b0; dbg_req = 1'b0;
        run(LAT + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
